gol_display_reader: RTL and testbench

- Display-side consumer of the double-buffered 256×256 Game of Life cell RAM; the update engine writes the update bank, this block reads the display bank.
- For each active grid row, prefetches 256 cells into a local line buffer during horizontal blanking, upscales them by 2^SCALE_LOG2 and maps species to 24-bit RGB.
- Aligns sync/DE to pixel output and emits video_sof, the engine's buffer-swap strobe.

---
 rtl/gol_pkg.sv | 47 ++++
 rtl/gol_line_buffer.sv | 23 ++
 rtl/gol_display_reader.sv | 188 ++++++++++++++++++
 tb/tb_gol_display_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared constants, types and palette for the Game of Life display path.
package gol_pkg;

  localparam int GRID_W    = 256;
  localparam int GRID_H    = 256;
  localparam int SPECIES_W = 4;
  localparam int COL_W     = 8;

  typedef logic [SPECIES_W-1:0] species_t;
  typedef logic [23:0]          rgb_t;

  localparam rgb_t PAL_0       = 24'h000000;
  localparam rgb_t PAL_1       = 24'hFF0000;
  localparam rgb_t PAL_2       = 24'h00FF00;
  localparam rgb_t PAL_3       = 24'h0000FF;
  localparam rgb_t PAL_4       = 24'hFFFF00;
  localparam rgb_t PAL_5       = 24'h00FFFF;
  localparam rgb_t PAL_6       = 24'hFF00FF;
  localparam rgb_t PAL_7       = 24'hFFFFFF;
  localparam rgb_t PAL_INVALID = 24'h808080;
  localparam rgb_t PAL_BORDER  = 24'h202020;
  localparam rgb_t PAL_GRID    = 24'h404040;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_t;

  // Species codes 8..15 are not produced by a healthy engine; show them grey.
  function automatic rgb_t species_colour(input species_t s);
    rgb_t c;
    case (s)
      4'd0:    c = PAL_0;
      4'd1:    c = PAL_1;
      4'd2:    c = PAL_2;
      4'd3:    c = PAL_3;
      4'd4:    c = PAL_4;
      4'd5:    c = PAL_5;
      4'd6:    c = PAL_6;
      4'd7:    c = PAL_7;
      default: c = PAL_INVALID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gol_line_buffer.sv
// One grid row of species codes; single write port, registered read port.
module gol_line_buffer
  import gol_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  species_t         wr_data,
  input  logic [COL_W-1:0] rd_addr,
  output species_t         rd_data
);

  species_t mem [GRID_W];

  // No reset on the storage so the array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gol_display_reader.sv
// Display-side reader: prefetches one grid row per line during hblank and emits
// upscaled RGB video. Define GOL_GRID_LINES_EN for the cell-grid overlay.
module gol_display_reader
  import gol_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int V_TOTAL    = 750,
  parameter int SCALE_LOG2 = 1,
  parameter int X_OFF      = 384,
  parameter int Y_OFF      = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        ram_select,
  input  logic        init_done,
  input  logic [3:0]  dout_bank0,
  input  logic [3:0]  dout_bank1,
  output logic [15:0] rd_addr,
  output logic [23:0] rgb,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        video_sof
);

  localparam logic [11:0] X_START   = 12'(X_OFF);
  localparam logic [11:0] X_END     = 12'(X_OFF + (GRID_W << SCALE_LOG2));
  localparam logic [11:0] Y_START   = 12'(Y_OFF);
  localparam logic [11:0] Y_END     = 12'(Y_OFF + (GRID_H << SCALE_LOG2));
  localparam logic [11:0] SUB_MASK  = 12'((1 << SCALE_LOG2) - 1);
  localparam logic [11:0] LAST_LINE = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_TRIG    = 12'(H_ACTIVE);
  localparam logic [11:0] V_SOF     = 12'(V_ACTIVE);

  fetch_state_t     state;
  logic             disp_bank;
  logic             wr_en_q;
  logic [COL_W-1:0] wr_idx_q;
  logic [11:0]      target_line;
  logic             trigger;
  logic             fetch_go;
  logic [7:0]       fetch_row;
  species_t         bank_data;

  assign target_line = (vcount == LAST_LINE) ? 12'd0 : vcount + 12'd1;
  assign trigger     = (hcount == H_TRIG);
  assign fetch_go    = trigger
                     && (target_line >= Y_START) && (target_line < Y_END)
                     && (((target_line - Y_START) & SUB_MASK) == 12'd0);
  assign fetch_row   = 8'((target_line - Y_START) >> SCALE_LOG2);
  assign bank_data   = disp_bank ? dout_bank1 : dout_bank0;

  // Prefetch FSM. rd_addr doubles as the column counter; the write side trails
  // it by one cycle to absorb the bank RAM read latency, hence the DRAIN state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      disp_bank <= 1'b0;
    end else begin
      wr_en_q  <= (state == ST_FETCH);
      wr_idx_q <= rd_addr[COL_W-1:0];
      if (trigger && (target_line == 12'd0)) begin
        disp_bank <= ram_select;
      end
      case (state)
        ST_IDLE: begin
          if (fetch_go) begin
            rd_addr <= {fetch_row, 8'h00};
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rd_addr[COL_W-1:0] == 8'hFF) begin
            state <= ST_DRAIN;
          end else begin
            rd_addr <= rd_addr + 16'd1;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  logic             in_col;
  logic             in_row;
  logic [COL_W-1:0] lb_raddr;
  species_t         cell_s1;

  assign in_col   = (hcount >= X_START) && (hcount < X_END);
  assign in_row   = (vcount >= Y_START) && (vcount < Y_END);
  assign lb_raddr = 8'((hcount - X_START) >> SCALE_LOG2);

  gol_line_buffer u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_idx_q),
    .wr_data (bank_data),
    .rd_addr (lb_raddr),
    .rd_data (cell_s1)
  );

`ifdef GOL_GRID_LINES_EN
  logic grid_line_s0;
  logic grid_line_s1;

  if (SCALE_LOG2 >= 2) begin : g_overlay
    assign grid_line_s0 = (((hcount - X_START) & SUB_MASK) == 12'd0)
                       || (((vcount - Y_START) & SUB_MASK) == 12'd0);
  end else begin : g_no_overlay
    assign grid_line_s0 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid_line_s1 <= 1'b0;
    end else begin
      grid_line_s1 <= grid_line_s0;
    end
  end
`endif

  logic de_s1;
  logic hs_s1;
  logic vs_s1;
  logic in_grid_s1;
  logic init_s1;
  rgb_t pix_colour;

  // Stage 1 runs alongside the line-buffer read so the flags meet the cell data.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_s1      <= 1'b0;
      hs_s1      <= 1'b0;
      vs_s1      <= 1'b0;
      in_grid_s1 <= 1'b0;
      init_s1    <= 1'b0;
    end else begin
      de_s1      <= de_in;
      hs_s1      <= hsync_in;
      vs_s1      <= vsync_in;
      in_grid_s1 <= in_col && in_row;
      init_s1    <= init_done;
    end
  end

  // Later assignments win: blanking beats init, init beats border, border beats palette.
  always_comb begin
    pix_colour = species_colour(cell_s1);
`ifdef GOL_GRID_LINES_EN
    if (grid_line_s1) begin
      pix_colour = PAL_GRID;
    end
`endif
    if (!in_grid_s1) begin
      pix_colour = PAL_BORDER;
    end
    if (!de_s1 || !init_s1) begin
      pix_colour = PAL_0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      video_sof <= 1'b0;
    end else begin
      rgb       <= pix_colour;
      de_out    <= de_s1;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      video_sof <= (hcount == 12'd0) && (vcount == V_SOF);
    end
  end

endmodule

// File: tb/tb_gol_display_reader.sv
// Self-checking bench for gol_display_reader: free-running timing generator,
// bank RAM models, pixel scoreboard and a table of hand-derived pixel probes.
module tb_gol_display_reader;

  localparam int H_ACTIVE   = 48;
  localparam int H_TOTAL    = 318;
  localparam int V_ACTIVE   = 10;
  localparam int V_TOTAL    = 14;
  localparam int SCALE_LOG2 = 1;
  localparam int X_OFF      = 8;
  localparam int Y_OFF      = 2;
  localparam int GRID_PIX   = 256 << SCALE_LOG2;

  typedef struct {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    bit          chk_rgb;
  } sb_entry_t;

  typedef struct {
    int          frame;
    int          h;
    int          v;
    logic [23:0] rgb;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        ram_select;
  logic        init_done;
  logic [3:0]  dout_bank0;
  logic [3:0]  dout_bank1;
  logic [15:0] rd_addr;
  logic [23:0] rgb;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        video_sof;

  logic [3:0] mem0 [65536];
  logic [3:0] mem1 [65536];

  sb_entry_t sb [$];
  probe_t    probes [$];

  int n_checks = 0;
  int n_pass   = 0;
  int h = 0, v = 0, frame = 0;
  int drv_h = 0, drv_v = 0, drv_frame = 0;
  int sof_in_frame = 0, sof_total = 0;
  bit prev_trig = 0, prev_sof = 0, prev_rst = 0;
  int prev_row = 0;
  bit model_bank = 0;
  bit rgb_trusted = 1;
  bit m_fetching = 0;
  logic [15:0] m_addr = '0;

  gol_display_reader #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .V_TOTAL    (V_TOTAL),
    .SCALE_LOG2 (SCALE_LOG2),
    .X_OFF      (X_OFF),
    .Y_OFF      (Y_OFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .de_in      (de_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .ram_select (ram_select),
    .init_done  (init_done),
    .dout_bank0 (dout_bank0),
    .dout_bank1 (dout_bank1),
    .rd_addr    (rd_addr),
    .rgb        (rgb),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .video_sof  (video_sof)
  );

  always #5 clk = ~clk;

  // Engine-side cell RAMs, one cycle read latency.
  always @(posedge clk) begin
    dout_bank0 <= mem0[rd_addr];
    dout_bank1 <= mem1[rd_addr];
  end

  function automatic int cell0(input int r, input int c);
    return (r + c) % 8;
  endfunction

  function automatic int cell1(input int r, input int c);
    return (r + 2 * c + 1) % 16;
  endfunction

  function automatic logic [23:0] pal(input int s);
    case (s)
      0: return 24'h000000;
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFF00;
      5: return 24'h00FFFF;
      6: return 24'hFF00FF;
      7: return 24'hFFFFFF;
      default: return 24'h808080;
    endcase
  endfunction

  function automatic logic [23:0] expPixel(input int ph, input int pv, input bit de,
                                           input bit init, input bit bank);
    int r, c;
    if (!de || !init) return 24'h000000;
    if (ph < X_OFF || ph >= X_OFF + GRID_PIX || pv < Y_OFF || pv >= Y_OFF + GRID_PIX)
      return 24'h202020;
    r = (pv - Y_OFF) >> SCALE_LOG2;
    c = (ph - X_OFF) >> SCALE_LOG2;
    return pal(bank ? cell1(r, c) : cell0(r, c));
  endfunction

  task automatic compare(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h (frame %0d line %0d pixel %0d)",
               name, act, exp, drv_frame, drv_v, drv_h);
    end
  endtask

  // Samples DUT outputs 1 time unit after the edge, before new inputs go out.
  task automatic checkOutput();
    sb_entry_t e;
    if (prev_rst) begin
      m_addr     = '0;
      m_fetching = 0;
    end else if (prev_trig) begin
      m_addr     = {8'(prev_row), 8'h00};
      m_fetching = 1;
    end else if (m_fetching) begin
      if (m_addr[7:0] == 8'hFF) m_fetching = 0;
      else m_addr = m_addr + 16'd1;
    end
    compare("rd_addr", 24'(rd_addr), 24'(m_addr));
    compare("video_sof", 24'(video_sof), 24'(prev_sof));
    if (video_sof) begin
      sof_in_frame++;
      sof_total++;
    end
    if (prev_rst) compare("rst_rd_addr", 24'(rd_addr), 24'h0);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      compare("de_out", 24'(de_out), 24'(e.de));
      compare("hsync_out", 24'(hsync_out), 24'(e.hs));
      compare("vsync_out", 24'(vsync_out), 24'(e.vs));
      if (e.chk_rgb) compare("rgb", rgb, e.rgb);
    end
  endtask

  task automatic applyStimulus();
    sb_entry_t e;
    int  tl;
    bit  de_now;
    if (frame == 0 && h == 0 && v == Y_OFF)     compare("fill_row0", 24'(rd_addr), 24'h0000FF);
    if (frame == 0 && h == 0 && v == Y_OFF + 1) compare("no_refill", 24'(rd_addr), 24'h0000FF);
    if (frame == 0 && h == 0 && v == Y_OFF + 2) compare("fill_row1", 24'(rd_addr), 24'h0001FF);
    if (h == 0 && v == 0) begin
      if (frame > 0) compare("sof_per_frame", 24'(sof_in_frame), 24'd1);
      sof_in_frame = 0;
      rgb_trusted  = 1;
    end

    rst        = (frame == 3 && v == Y_OFF + 1 && h == H_ACTIVE + 50);
    ram_select = !(frame == 0 && v < 5);
    init_done  = (frame != 2);
    de_now     = (h < H_ACTIVE) && (v < V_ACTIVE);
    hcount     = 12'(h);
    vcount     = 12'(v);
    de_in      = de_now;
    hsync_in   = (h >= H_ACTIVE + 10) && (h < H_ACTIVE + 40);
    vsync_in   = (v == V_ACTIVE + 1) || (v == V_ACTIVE + 2);

    tl        = (v == V_TOTAL - 1) ? 0 : v + 1;
    prev_trig = !rst && (h == H_ACTIVE) && (tl >= Y_OFF) && (tl < Y_OFF + GRID_PIX)
                && (((tl - Y_OFF) % (1 << SCALE_LOG2)) == 0);
    prev_row  = (tl - Y_OFF) >> SCALE_LOG2;
    prev_sof  = !rst && (h == 0) && (v == V_ACTIVE);
    prev_rst  = rst;

    if (rst) begin
      sb.delete();
      e = '{rgb: 24'h0, de: 1'b0, hs: 1'b0, vs: 1'b0, chk_rgb: 1'b1};
      sb.push_back(e);
      sb.push_back(e);
      model_bank  = 0;
      rgb_trusted = 0;
    end else begin
      e.rgb     = expPixel(h, v, de_now, init_done, model_bank);
      e.de      = de_now;
      e.hs      = hsync_in;
      e.vs      = vsync_in;
      e.chk_rgb = rgb_trusted;
      sb.push_back(e);
      if (h == H_ACTIVE && tl == 0) model_bank = ram_select;
    end

    drv_frame = frame;
    drv_h     = h;
    drv_v     = v;
    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v++;
      if (v == V_TOTAL) begin
        v = 0;
        frame++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
    applyStimulus();
  endtask

  initial begin
    int  guard;
    bit  timed_out;
    for (int r = 0; r < 256; r++) begin
      for (int c = 0; c < 256; c++) begin
        mem0[r * 256 + c] = 4'(cell0(r, c));
        mem1[r * 256 + c] = 4'(cell1(r, c));
      end
    end

    // Hand-derived probes, time-ordered. Bank0 = (r+c)%8, bank1 = (r+2c+1)%16.
    probes.push_back('{frame: 0, h: 30, v: 1, rgb: 24'h202020});
    probes.push_back('{frame: 0, h: 8,  v: 2, rgb: 24'h000000});
    probes.push_back('{frame: 0, h: 10, v: 2, rgb: 24'hFF0000});
    probes.push_back('{frame: 0, h: 12, v: 3, rgb: 24'h00FF00});
    probes.push_back('{frame: 0, h: 20, v: 4, rgb: 24'hFFFFFF});
    probes.push_back('{frame: 0, h: 50, v: 4, rgb: 24'h000000});
    probes.push_back('{frame: 0, h: 7,  v: 6, rgb: 24'h202020});
    probes.push_back('{frame: 0, h: 14, v: 6, rgb: 24'h00FFFF});
    probes.push_back('{frame: 0, h: 16, v: 8, rgb: 24'hFFFFFF});
    probes.push_back('{frame: 1, h: 8,  v: 2, rgb: 24'hFF0000});
    probes.push_back('{frame: 1, h: 10, v: 4, rgb: 24'hFFFF00});
    probes.push_back('{frame: 1, h: 14, v: 6, rgb: 24'h808080});
    probes.push_back('{frame: 1, h: 16, v: 8, rgb: 24'h808080});
    probes.push_back('{frame: 1, h: 8,  v: 9, rgb: 24'hFFFF00});
    probes.push_back('{frame: 2, h: 7,  v: 6, rgb: 24'h000000});
    probes.push_back('{frame: 2, h: 14, v: 6, rgb: 24'h000000});
    probes.push_back('{frame: 3, h: 10, v: 2, rgb: 24'h0000FF});
    probes.push_back('{frame: 4, h: 12, v: 2, rgb: 24'h00FFFF});
    probes.push_back('{frame: 4, h: 10, v: 4, rgb: 24'hFFFF00});
    probes.push_back('{frame: 4, h: 14, v: 6, rgb: 24'h808080});

    rst        = 1'b1;
    hcount     = '0;
    vcount     = '0;
    de_in      = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    ram_select = 1'b0;
    init_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_rd_addr", 24'(rd_addr), 24'h0);
    compare("reset_rgb", rgb, 24'h0);
    compare("reset_de_out", 24'(de_out), 24'h0);
    compare("reset_hsync_out", 24'(hsync_out), 24'h0);
    compare("reset_vsync_out", 24'(vsync_out), 24'h0);
    compare("reset_video_sof", 24'(video_sof), 24'h0);
    applyStimulus();

    timed_out = 0;
    foreach (probes[i]) begin
      guard = 0;
      while (!(drv_frame == probes[i].frame && drv_h == probes[i].h && drv_v == probes[i].v)
             && guard < 30000) begin
        tick();
        guard++;
      end
      if (guard >= 30000) begin
        n_checks++;
        $display("[TB] FAIL probe_timeout: probe %0d not reached, got none required frame %0d line %0d pixel %0d",
                 i, probes[i].frame, probes[i].v, probes[i].h);
        timed_out = 1;
        break;
      end
      tick();
      tick();
      compare($sformatf("probe%0d_rgb", i), rgb, probes[i].rgb);
    end

    if (!timed_out) begin
      guard = 0;
      while (drv_frame < 5 && guard < 30000) begin
        tick();
        guard++;
      end
      compare("sof_total", 24'(sof_total), 24'd5);
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
